prime_scan_ctrl: RTL and testbench
==================================

PRIME_SCAN_CTRL -- requirements
Module: prime_scan_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of candidates, bounds, prime_out and prime_count.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a scan; sampled only in IDLE.
REQ-005 lo  input  WIDTH  lower bound, inclusive; latched on accepted start.
REQ-006 hi  input  WIDTH  upper bound, inclusive; latched on accepted start.
REQ-007 busy  output  1  high in SCAN and EMIT.
REQ-008 done  output  1  one-cycle pulse when a scan completes.
REQ-009 prime_out  output  WIDTH  current prime; valid only while prime_valid=1.
REQ-010 prime_valid  output  1  prime_out holds a prime awaiting acceptance.
REQ-011 prime_ready  input  1  consumer accepts prime_out when prime_valid=1 at the same edge.
REQ-012 prime_count  output  WIDTH  primes accepted in current/last scan; held after done until next accepted start.

Function
REQ-013 The block SHALL instantiate one combinational prime_check #(WIDTH) (number -> is_prime; 0 and 1 not prime) and drive its number input from internal register cand.
REQ-014 The FSM SHALL have states IDLE, SCAN, EMIT, DONE; encoding is free.
REQ-015 IDLE: start=1 SHALL latch lo/hi, set cand=lo, clear prime_count, and go to SCAN, or go to DONE directly if lo>hi.
REQ-016 SCAN: each cycle tests cand; is_prime=1 -> EMIT with prime_out=cand; otherwise cand==hi -> DONE, else cand<=cand+1 and stay in SCAN.
REQ-017 Non-prime candidates SHALL cost exactly one cycle each; no idle cycles between candidates.
REQ-018 EMIT: prime_valid=1, prime_out stable; held until prime_valid&&prime_ready at an edge.
REQ-019 EMIT handshake edge: prime_count increments; cand==hi -> DONE, else cand<=cand+1 and go to SCAN.
REQ-020 prime_valid and prime_out SHALL NOT change in EMIT while prime_ready=0.
REQ-021 DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
REQ-022 Termination SHALL use cand==hi equality, never cand>hi, so hi=2^WIDTH-1 terminates without wrap-around and cand never exceeds hi.
REQ-023 start SHALL be ignored in SCAN, EMIT and DONE; lo/hi changes after latching SHALL have no effect.
REQ-024 lo==hi SHALL scan exactly one candidate.
REQ-025 prime_count SHALL NOT overflow in any scan; the 0..2^WIDTH-1 prime count fits in WIDTH bits for WIDTH>=4.
REQ-026 With prime_ready held at 1, start-to-done latency SHALL be (hi-lo+1)+P+1 cycles, where P is the number of primes in range; done asserts in the cycle after the last SCAN/EMIT cycle.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, cand=0, prime_out=0, prime_count=0, and deassert busy, done and prime_valid, regardless of state.
REQ-028 Reset mid-scan or mid-EMIT SHALL drop prime_valid immediately with no handshake and no done pulse.
REQ-029 Outputs SHALL remain at reset values while rst=1; start SHALL be ignored while rst=1.

Verification
REQ-030 lo=0, hi=20, prime_ready=1 -> prime_out 2,3,5,7,11,13,17,19 in order; prime_count=8; done pulses 30 cycles after start edge.
REQ-031 lo=0, hi=20, prime_ready toggling 0/1 pseudo-randomly -> same 8 primes, none duplicated or dropped, prime_out stable while stalled, prime_count=8.
REQ-032 lo=250, hi=255 -> single prime 251, prime_count=1, done pulses, scan terminates (no wrap to 0).
REQ-033 lo=9, hi=3 -> no prime_valid; done one cycle after start; prime_count=0. lo=hi=7 -> one prime 7.
REQ-034 start pulsed again while busy with different lo/hi -> ignored; original scan results unchanged.
REQ-035 rst asserted while in EMIT on prime 5 of 0..20 -> next cycle IDLE, all outputs zero; new scan 0..20 gives full correct result.

Source files
------------

// File: rtl/prime_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prime_check
// Description : Combinational primality test by trial division. 0 and 1 are
//               not prime. Divisors run up to 2^ceil(WIDTH/2)-1, which always
//               covers floor(sqrt(2^WIDTH-1)).
// Ports       : number   - candidate value (WIDTH bits)
//               is_prime - 1 when number is prime
// Revision    : 1.0 - initial release
// ============================================================================
module prime_check #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] number,
    output logic             is_prime
);

    // Exclusive upper bound for trial divisors.
    localparam int C_DIV_LIMIT = 1 << ((WIDTH + 1) / 2);

    int w_n;

    always_comb begin
        w_n      = int'(number);
        is_prime = (w_n >= 2);
        for (int d = 2; d < C_DIV_LIMIT; d++) begin
            // Only divisors with d*d <= n matter; larger ones are inert.
            if ((d * d <= w_n) && ((w_n % d) == 0)) begin
                is_prime = 1'b0;
            end
        end
    end

endmodule

// ============================================================================
// Module      : prime_scan_ctrl
// Description : Scans the inclusive range [lo, hi] one candidate per cycle and
//               presents each prime on a valid/ready output, counting the
//               primes accepted by the consumer. A one-cycle done pulse marks
//               the end of each scan.
// Ports       : clk         - clock, rising edge active
//               rst         - synchronous active-high reset
//               start       - scan request, honoured only in IDLE
//               lo, hi      - inclusive bounds, latched on accepted start
//               busy        - high while scanning or emitting a prime
//               done        - one-cycle completion pulse
//               prime_out   - current prime, valid while prime_valid=1
//               prime_valid - prime_out holds a prime awaiting acceptance
//               prime_ready - consumer accepts prime_out at this edge
//               prime_count - primes accepted in the current/last scan
// Revision    : 1.0 - initial release
// ============================================================================
module prime_scan_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prime_out,
    output logic             prime_valid,
    input  logic             prime_ready,
    output logic [WIDTH-1:0] prime_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_prime_out;
    logic [WIDTH-1:0] r_prime_count;
    logic             w_is_prime;
    logic             w_last;

    prime_check #(
        .WIDTH (WIDTH)
    ) u_prime_check (
        .number   (r_cand),
        .is_prime (w_is_prime)
    );

    // Equality (not cand > hi) ends the scan, so hi = all-ones never wraps.
    assign w_last = (r_cand == r_hi);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (lo > hi) ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (w_is_prime) begin
                    w_state_next = EMIT;
                end else if (w_last) begin
                    w_state_next = DONE;
                end
            end
            EMIT: begin
                if (prime_ready) begin
                    w_state_next = w_last ? DONE : SCAN;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand        <= '0;
            r_hi          <= '0;
            r_prime_out   <= '0;
            r_prime_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cand        <= lo;
                        r_hi          <= hi;
                        r_prime_count <= '0;
                    end
                end
                SCAN: begin
                    if (w_is_prime) begin
                        r_prime_out <= r_cand;
                    end else if (!w_last) begin
                        r_cand <= r_cand + WIDTH'(1);
                    end
                end
                EMIT: begin
                    if (prime_ready) begin
                        r_prime_count <= r_prime_count + WIDTH'(1);
                        if (!w_last) begin
                            r_cand <= r_cand + WIDTH'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (Moore, decoded from state)
    // ------------------------------------------------------------------
    assign busy        = (r_state == SCAN) || (r_state == EMIT);
    assign done        = (r_state == DONE);
    assign prime_valid = (r_state == EMIT);
    assign prime_out   = r_prime_out;
    assign prime_count = r_prime_count;

endmodule
`default_nettype wire

// File: tb/tb_prime_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prime_scan_ctrl
// Description : Self-checking bench for prime_scan_ctrl. A trial-division
//               reference computes the expected prime list, count and
//               start-to-done latency for each scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prime_scan_ctrl;

    localparam int W = 8;

    logic         clk         = 1'b0;
    logic         rst         = 1'b1;
    logic         start       = 1'b0;
    logic         prime_ready = 1'b0;
    logic [W-1:0] lo          = '0;
    logic [W-1:0] hi          = '0;
    logic         busy;
    logic         done;
    logic         prime_valid;
    logic [W-1:0] prime_out;
    logic [W-1:0] prime_count;

    prime_scan_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .lo          (lo),
        .hi          (hi),
        .busy        (busy),
        .done        (done),
        .prime_out   (prime_out),
        .prime_valid (prime_valid),
        .prime_ready (prime_ready),
        .prime_count (prime_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int got_q[$];
    int exp_q[$];
    int got_latency;
    int got_count;
    int got_pulses;
    int got_stall_err;
    int got_busy_err;
    bit got_timeout;

    // ---------------- reference model ----------------
    function automatic bit ref_is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic build_expected(input int a, input int b);
        exp_q.delete();
        for (int n = a; n <= b; n++) begin
            if (ref_is_prime(n)) exp_q.push_back(n);
        end
    endtask

    function automatic int exp_latency(input int a, input int b);
        if (a > b) return 1;
        return (b - a + 1) + exp_q.size() + 1;
    endfunction

    function automatic bit lists_equal();
        if (got_q.size() != exp_q.size()) return 1'b0;
        foreach (got_q[i]) begin
            if (got_q[i] != exp_q[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic string list_str(input int q[$]);
        string s;
        s = "";
        foreach (q[i]) s = $sformatf("%s%0d ", s, q[i]);
        return s;
    endfunction

    // ---------------- stimulus driver ----------------
    // Starts a scan, scrambles lo/hi every cycle after the start edge, and
    // records accepted primes, latency, done pulses and protocol violations.
    // rmode 0: prime_ready held high; rmode 1: random prime_ready.
    task automatic run_scan(input int slo, input int shi, input int rmode, input bit restart_mid);
        int           e;
        bit           prev_stall;
        logic [W-1:0] prev_out;
        bit           finished;
        got_q.delete();
        got_latency   = -1;
        got_pulses    = 0;
        got_stall_err = 0;
        got_busy_err  = 0;
        got_timeout   = 1'b0;
        e             = 0;
        prev_stall    = 1'b0;
        prev_out      = '0;
        finished      = 1'b0;
        lo            = W'(slo);
        hi            = W'(shi);
        start         = 1'b1;
        prime_ready   = (rmode == 0);
        @(posedge clk); #1;
        start = 1'b0;
        while (!finished) begin
            lo    = W'($urandom);
            hi    = W'($urandom);
            start = (restart_mid && (e == 2 || e == 5));
            if (prev_stall && (!prime_valid || prime_out !== prev_out)) got_stall_err++;
            if (done) begin
                got_pulses++;
                if (got_latency < 0) got_latency = e + 1;
                if (busy) got_busy_err++;
            end else if (got_latency < 0) begin
                if (!busy) got_busy_err++;
            end else begin
                if (busy) got_busy_err++;
                finished = 1'b1;
            end
            if (rmode != 0) prime_ready = ($urandom % 2 == 1);
            if (prime_valid) begin
                if (prime_ready) got_q.push_back(int'(prime_out));
                prev_stall = !prime_ready;
                prev_out   = prime_out;
            end else begin
                prev_stall = 1'b0;
            end
            if (!finished) begin
                @(posedge clk); #1;
                e++;
                if (e > 4000) begin
                    got_timeout = 1'b1;
                    finished    = 1'b1;
                end
            end
        end
        start       = 1'b0;
        prime_ready = 1'b0;
        got_count   = int'(prime_count);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            lo = W'($urandom % 8);
            hi = W'(20 + $urandom % 8);
            @(posedge clk); #1;
            vectors++;
            if ({busy, done, prime_valid, prime_out, prime_count} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got busy=%b done=%b valid=%b out=%0d count=%0d, required all zero",
                         busy, done, prime_valid, prime_out, prime_count);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start_ignored: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_basic();
        run_scan(0, 20, 0, 1'b0);
        build_expected(0, 20);
        vectors++;
        if (!lists_equal()) begin
            miscompares++;
            $display("FAIL basic_list: got [%s] required [%s]", list_str(got_q), list_str(exp_q));
        end
        vectors++;
        if (got_count != 8) begin
            miscompares++;
            $display("FAIL basic_count: got %0d required 8", got_count);
        end
        vectors++;
        if (got_latency != 30) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d required 30", got_latency);
        end
        vectors++;
        if (got_pulses != 1 || got_busy_err != 0 || got_timeout) begin
            miscompares++;
            $display("FAIL basic_protocol: got pulses=%0d busy_err=%0d timeout=%0d required 1/0/0",
                     got_pulses, got_busy_err, got_timeout);
        end
    endtask

    task automatic test_backpressure();
        run_scan(0, 20, 1, 1'b0);
        build_expected(0, 20);
        vectors++;
        if (!lists_equal()) begin
            miscompares++;
            $display("FAIL bp_list: got [%s] required [%s]", list_str(got_q), list_str(exp_q));
        end
        vectors++;
        if (got_count != 8) begin
            miscompares++;
            $display("FAIL bp_count: got %0d required 8", got_count);
        end
        vectors++;
        if (got_stall_err != 0 || got_pulses != 1 || got_timeout) begin
            miscompares++;
            $display("FAIL bp_stall: got stall_err=%0d pulses=%0d timeout=%0d required 0/1/0",
                     got_stall_err, got_pulses, got_timeout);
        end
    endtask

    task automatic test_top_range();
        run_scan(250, 255, 1, 1'b0);
        build_expected(250, 255);
        vectors++;
        if (!lists_equal() || got_count != 1) begin
            miscompares++;
            $display("FAIL top_range: got [%s] count=%0d required [%s] count=1",
                     list_str(got_q), got_count, list_str(exp_q));
        end
        vectors++;
        if (got_timeout || got_pulses != 1) begin
            miscompares++;
            $display("FAIL top_range_term: got timeout=%0d pulses=%0d required 0/1", got_timeout, got_pulses);
        end
        run_scan(0, 255, 0, 1'b0);
        build_expected(0, 255);
        vectors++;
        if (!lists_equal() || got_count != 54 || got_latency != exp_latency(0, 255)) begin
            miscompares++;
            $display("FAIL full_range: got n=%0d count=%0d lat=%0d required n=%0d count=54 lat=%0d",
                     got_q.size(), got_count, got_latency, exp_q.size(), exp_latency(0, 255));
        end
    endtask

    task automatic test_empty_and_single();
        run_scan(9, 3, 0, 1'b0);
        vectors++;
        if (got_q.size() != 0 || got_count != 0 || got_latency != 1 || got_pulses != 1) begin
            miscompares++;
            $display("FAIL empty_range: got n=%0d count=%0d lat=%0d pulses=%0d required 0/0/1/1",
                     got_q.size(), got_count, got_latency, got_pulses);
        end
        run_scan(7, 7, 0, 1'b0);
        build_expected(7, 7);
        vectors++;
        if (!lists_equal() || got_count != 1 || got_latency != exp_latency(7, 7)) begin
            miscompares++;
            $display("FAIL single_prime: got [%s] count=%0d lat=%0d required [%s] count=1 lat=%0d",
                     list_str(got_q), got_count, got_latency, list_str(exp_q), exp_latency(7, 7));
        end
        run_scan(8, 8, 0, 1'b0);
        vectors++;
        if (got_q.size() != 0 || got_count != 0 || got_latency != 2) begin
            miscompares++;
            $display("FAIL single_composite: got n=%0d count=%0d lat=%0d required 0/0/2",
                     got_q.size(), got_count, got_latency);
        end
    endtask

    task automatic test_ignored_start();
        run_scan(0, 20, 0, 1'b1);
        build_expected(0, 20);
        vectors++;
        if (!lists_equal() || got_count != 8 || got_latency != 30) begin
            miscompares++;
            $display("FAIL restart_ignored: got [%s] count=%0d lat=%0d required [%s] count=8 lat=30",
                     list_str(got_q), got_count, got_latency, list_str(exp_q));
        end
    endtask

    task automatic test_reset_in_emit();
        bit found;
        found       = 1'b0;
        lo          = W'(0);
        hi          = W'(20);
        start       = 1'b1;
        prime_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (prime_valid && prime_out == W'(5)) begin
                found = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL rst_emit_reach: got no EMIT on 5, required EMIT on 5");
        end
        prime_ready = 1'b0;
        rst         = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({busy, done, prime_valid, prime_out, prime_count} !== '0) begin
            miscompares++;
            $display("FAIL rst_emit_outputs: got busy=%b done=%b valid=%b out=%0d count=%0d, required all zero",
                     busy, done, prime_valid, prime_out, prime_count);
        end
        start = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || prime_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_hold: got done=%b valid=%b busy=%b required 0/0/0", done, prime_valid, busy);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        run_scan(0, 20, 0, 1'b0);
        build_expected(0, 20);
        vectors++;
        if (!lists_equal() || got_count != 8 || got_latency != 30) begin
            miscompares++;
            $display("FAIL rst_rescan: got [%s] count=%0d lat=%0d required [%s] count=8 lat=30",
                     list_str(got_q), got_count, got_latency, list_str(exp_q));
        end
    endtask

    task automatic test_random();
        int a;
        int b;
        int t;
        int m;
        for (int it = 0; it < 8; it++) begin
            a = int'($urandom % 256);
            b = a + int'($urandom % 40);
            if (b > 255) b = 255;
            if ($urandom % 5 == 0 && a != b) begin
                t = a; a = b; b = t;
            end
            m = int'($urandom % 2);
            run_scan(a, b, m, 1'b0);
            build_expected(a, b);
            vectors++;
            if (!lists_equal() || got_count != exp_q.size()) begin
                miscompares++;
                $display("FAIL rand_%0d_list lo=%0d hi=%0d: got [%s] count=%0d required [%s]",
                         it, a, b, list_str(got_q), got_count, list_str(exp_q));
            end
            vectors++;
            if (got_pulses != 1 || got_stall_err != 0 || got_busy_err != 0 || got_timeout) begin
                miscompares++;
                $display("FAIL rand_%0d_protocol: got pulses=%0d stall=%0d busy=%0d timeout=%0d required 1/0/0/0",
                         it, got_pulses, got_stall_err, got_busy_err, got_timeout);
            end
            if (m == 0) begin
                vectors++;
                if (got_latency != exp_latency(a, b)) begin
                    miscompares++;
                    $display("FAIL rand_%0d_latency: got %0d required %0d", it, got_latency, exp_latency(a, b));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_top_range();
        test_empty_and_single();
        test_ignored_start();
        test_reset_in_emit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
